fetch_stage: RTL and testbench

Clocked instruction-fetch stage at the head of the pipeline, directly upstream of the decode stage (stage1). Holds the program counter, issues one read per cycle to a synchronous instruction memory, buffers returned bytes in a small FIFO, and presents {pc, instruction} to the downstream stage over a valid/ready handshake. A redirect input from later stages restarts fetch at a new address and discards everything in flight.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 40 ++++
 rtl/fetch_fifo.sv | 104 ++++++++++
 rtl/fetch_fifo_chk.sv | 24 ++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 6 files changed

// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage: default address/data
// widths, the layout of one buffered fetch entry {pc, data}, its width, and
// the program counter value loaded at reset.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // One buffered fetch result; pc sits in the upper bits.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] data;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Fetch restarts here after reset.
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's external traffic:
//   memory side   : mem_rd, mem_addr (to memory), mem_data (from memory)
//   redirect side : redirect, redirect_pc (from later pipeline stages)
//   output side   : out_valid, out_pc, out_data (to decode), out_ready (from decode)
// master = fetch stage, slave = its environment (memory + downstream).
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output mem_rd, mem_addr,
    input  mem_data,
    input  redirect, redirect_pc,
    output out_valid, out_pc, out_data,
    input  out_ready
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_data,
    output redirect, redirect_pc,
    input  out_valid, out_pc, out_data,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous circular FIFO of DEPTH entries holding fetched {pc, data}.
// Ports: clk, rst (sync, active-high), push_i/push_data_i, pop_i, clear_i
// (drops all contents; wins over push/pop), count_o, head_valid_o,
// head_data_o (zero when empty).
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter  int WIDTH = ENTRY_W,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             head_valid_o,
  output logic [WIDTH-1:0] head_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop_s;

  // Pointer advance with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  assign do_pop_s = pop_i & (count_q != {CNT_W{1'b0}});

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (clear_i) begin
      rd_d    = {PTR_W{1'b0}};
      wr_d    = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (push_i) begin
        wr_d = next_ptr(wr_q);
      end else begin
        wr_d = wr_q;
      end
      if (do_pop_s) begin
        rd_d = next_ptr(rd_q);
      end else begin
        rd_d = rd_q;
      end
      case ({push_i, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= {PTR_W{1'b0}};
      wr_q    <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset because the head is gated by count.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != {CNT_W{1'b0}});
  assign head_data_o  = head_valid_o ? mem_q[rd_q] : {WIDTH{1'b0}};

  fetch_fifo_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_i),
    .clear_i (clear_i),
    .count_i (count_q)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// -----------------------------------------------------------------------------
// fetch_fifo_chk
// Property checker for fetch_fifo: a push must never land on a full FIFO.
// Ports: clk, rst, push_i, clear_i, count_i (current occupancy).
// -----------------------------------------------------------------------------
module fetch_fifo_chk #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst,
  input logic             push_i,
  input logic             clear_i,
  input logic [CNT_W-1:0] count_i
);

  // Overflow check: the issue rule keeps one slot free for every returning read.
  always_ff @(posedge clk) begin
    if (!rst && push_i && !clear_i) begin
      assert (count_i < CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: holds the PC, issues one read per cycle to a 1-cycle
// synchronous memory, buffers results in fetch_fifo and hands {pc, data} to
// decode over valid/ready. A redirect flushes everything and restarts at
// redirect_pc; reads already issued are dropped via an epoch bit.
// Ports: clk, rst (sync, active-high), bus (fetch_stage_if.master: memory
// read port, redirect request, downstream valid/ready channel).
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 2
) (
  input logic            clk,
  input logic            rst,
  fetch_stage_if.master  bus
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              epoch_q, epoch_d;
  logic              inflight_epoch_q, inflight_epoch_d;

  logic [CNT_W-1:0]  count_s;
  logic              head_valid_s;
  logic [ENT_W-1:0]  head_s;
  logic [ENT_W-1:0]  push_data_s;
  logic [OCC_W-1:0]  occ_s;
  logic              pop_s, push_s, issue_s;

  assign pop_s = head_valid_s & bus.out_ready;

  // Occupancy counts buffered entries plus the read still in the memory.
  assign occ_s = OCC_W'(count_s) + OCC_W'(inflight_q);

  // A full stage may still issue when the head leaves this cycle: the slot it
  // frees is taken by the read returning next cycle, giving back-to-back flow.
  assign issue_s = !rst & !bus.redirect &
                   ((occ_s < OCC_W'(DEPTH)) | ((occ_s == OCC_W'(DEPTH)) & pop_s));

  // Stale returns (issued before a redirect) fail the epoch match.
  assign push_s      = inflight_q & (inflight_epoch_q == epoch_q) & !bus.redirect & !rst;
  assign push_data_s = {inflight_pc_q, bus.mem_data};

  // Next-state for PC, epoch and the in-flight read tracker.
  always_comb begin
    pc_d             = pc_q;
    epoch_d          = epoch_q;
    inflight_d       = issue_s;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      epoch_d = ~epoch_q;
    end else if (issue_s) begin
      pc_d    = pc_q + ADDR_W'(1'b1);
      epoch_d = epoch_q;
    end else begin
      pc_d    = pc_q;
      epoch_d = epoch_q;
    end
    if (issue_s) begin
      inflight_pc_d    = pc_q;
      inflight_epoch_d = epoch_q;
    end else begin
      inflight_pc_d    = inflight_pc_q;
      inflight_epoch_d = inflight_epoch_q;
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC[ADDR_W-1:0];
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= {ADDR_W{1'b0}};
      inflight_epoch_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
    end
  end

  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_s),
    .push_data_i  (push_data_s),
    .pop_i        (pop_s),
    .clear_i      (bus.redirect),
    .count_o      (count_s),
    .head_valid_o (head_valid_s),
    .head_data_o  (head_s)
  );

  assign bus.mem_rd    = issue_s;
  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = head_valid_s;
  assign bus.out_pc    = head_s[ENT_W-1 -: ADDR_W];
  assign bus.out_data  = head_s[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Memory model returns mem[a] = a + 0x10.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fetch_stage_if #(.ADDR_W(8), .DATA_W(8)) fif ();

  fetch_stage #(.ADDR_W(8), .DATA_W(8), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory, latency 1.
  always @(posedge clk) begin
    if (fif.mem_rd) fif.mem_data <= fif.mem_addr + 8'h10;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [7:0] pc, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(fif.out_valid), 32'(v));
    chk({tag, "_pc"},    32'(fif.out_pc),    32'(pc));
    chk({tag, "_data"},  32'(fif.out_data),  32'(d));
  endtask

  task automatic exp_mem(input string tag, input logic rd, input logic [7:0] addr);
    chk({tag, "_mem_rd"}, 32'(fif.mem_rd), 32'(rd));
    if (rd) chk({tag, "_mem_addr"}, 32'(fif.mem_addr), 32'(addr));
  endtask

  task automatic step(input logic r, input logic rdy, input logic rdr, input logic [7:0] rpc);
    @(negedge clk);
    rst             = r;
    fif.out_ready   = rdy;
    fif.redirect    = rdr;
    fif.redirect_pc = rpc;
    #1;
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    fif.out_ready   = 1'b1;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 8'h00;

    // Reset state
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    exp_mem("rst", 1'b0, 8'h00);
    exp_out("rst", 1'b0, 8'h00, 8'h00);

    // A: streaming with out_ready=1, first valid in cycle 2
    for (int c = 0; c <= 6; c++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      if (c < 2) begin
        exp_out($sformatf("A%0d", c), 1'b0, 8'h00, 8'h00);
      end else begin
        exp_out($sformatf("A%0d", c), 1'b1, 8'(c - 2), 8'(c - 2 + 16));
      end
      exp_mem($sformatf("A%0d", c), 1'b1, 8'(c));
    end

    // B: backpressure during cycles 2..9, release at cycle 10
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c <= 14; c++) begin
      step(1'b0, (c >= 10) ? 1'b1 : 1'b0, 1'b0, 8'h00);
      if (c < 2) begin
        exp_out($sformatf("B%0d", c), 1'b0, 8'h00, 8'h00);
        exp_mem($sformatf("B%0d", c), 1'b1, 8'(c));
      end else if (c < 10) begin
        exp_out($sformatf("B%0d", c), 1'b1, 8'h00, 8'h10);
        exp_mem($sformatf("B%0d", c), 1'b0, 8'h00);
      end else begin
        exp_out($sformatf("B%0d", c), 1'b1, 8'(c - 10), 8'(c - 10 + 16));
        exp_mem($sformatf("B%0d", c), 1'b1, 8'(c - 8));
      end
    end

    // C: redirect to 0x40 with an entry buffered and a read in flight
    step(1'b0, 1'b0, 1'b1, 8'h40);
    exp_out("C15", 1'b1, 8'h05, 8'h15);
    exp_mem("C15", 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("C16", 1'b0, 8'h00, 8'h00);
    exp_mem("C16", 1'b1, 8'h40);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("C17", 1'b0, 8'h00, 8'h00);
    exp_mem("C17", 1'b1, 8'h41);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("C18", 1'b1, 8'h40, 8'h50);
    exp_mem("C18", 1'b1, 8'h42);

    // D: redirect with a pop in the same cycle, then a second redirect
    step(1'b0, 1'b1, 1'b1, 8'h80);
    exp_out("D19", 1'b1, 8'h41, 8'h51);
    exp_mem("D19", 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hA0);
    exp_out("D20", 1'b0, 8'h00, 8'h00);
    exp_mem("D20", 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("D21", 1'b0, 8'h00, 8'h00);
    exp_mem("D21", 1'b1, 8'hA0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("D22", 1'b0, 8'h00, 8'h00);
    exp_mem("D22", 1'b1, 8'hA1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("D23", 1'b1, 8'hA0, 8'hB0);
    exp_mem("D23", 1'b1, 8'hA2);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("D24", 1'b1, 8'hA1, 8'hB1);

    // E: restart at 0xFE, pc wraps through 0xFF to 0x00
    step(1'b0, 1'b1, 1'b1, 8'hFE);
    exp_out("E25", 1'b1, 8'hA2, 8'hB2);
    exp_mem("E25", 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("E26", 1'b0, 8'h00, 8'h00);
    exp_mem("E26", 1'b1, 8'hFE);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_mem("E27", 1'b1, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("E28", 1'b1, 8'hFE, 8'h0E);
    exp_mem("E28", 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("E29", 1'b1, 8'hFF, 8'h0F);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("E30", 1'b1, 8'h00, 8'h10);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("E31", 1'b1, 8'h01, 8'h11);

    // F: fill, then reset together with redirect
    step(1'b0, 1'b0, 1'b0, 8'h00);
    exp_out("F32", 1'b1, 8'h02, 8'h12);
    exp_mem("F32", 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    exp_out("F33", 1'b1, 8'h02, 8'h12);
    exp_mem("F33", 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h77);
    exp_mem("F34", 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    exp_out("F35", 1'b0, 8'h00, 8'h00);
    exp_mem("F35", 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("F36", 1'b0, 8'h00, 8'h00);
    exp_mem("F36", 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_mem("F37", 1'b1, 8'h01);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("F38", 1'b1, 8'h00, 8'h10);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_out("F39", 1'b1, 8'h01, 8'h11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
